// File: rtl/pwm_peripheral.sv
// PWM output stage fed by the SPI register file.
// A prescaler divides clk into PWM counter steps. An 8-bit counter produces a
// shared waveform whose duty is shadowed at each period boundary. Each of the
// 16 pins is forced low, held high, or driven with that waveform, and all pin
// drives are registered.
`timescale 1ns/1ps
module pwm_peripheral #(
  parameter int PRESCALE = 13,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] pre_q,  pre_d;
  logic [7:0]       cnt_q,  cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic [15:0]      out_q,  out_d;
  logic             wrap_q, wrap_d;
  logic             ps_q,   ps_d;

  logic             tick;
  logic             pwm_raw;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;

  // Per-pin drive: disabled pins are low, enabled non-PWM pins are high,
  // enabled PWM pins follow the shared waveform.
  function automatic logic [15:0] pin_select(input logic [15:0] eo,
                                             input logic [15:0] ep,
                                             input logic        raw);
    pin_select = eo & (~ep | {16{raw}});
  endfunction

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Prescaler tick, waveform compare, and next-state for every register.
  always_comb begin
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    wrap_d  = 1'b0;
    tick    = (pre_q == PRE_MAX);
    // 0xFF is treated as a full-on duty so there is no dip at count 255.
    pwm_raw = (duty_q == 8'hFF) ? 1'b1 : (cnt_q < duty_q);

    if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == 8'hFF) begin
        // Shadow the duty only as the counter wraps so a period is never cut
        // short or stretched by a mid-period write.
        duty_d = pwm_duty_cycle;
        wrap_d = 1'b1;
      end
    end else begin
      pre_d = pre_q + CNT_W'(1);
    end

    out_d = pin_select(en_out, en_pwm, pwm_raw);
    // wrap_q marks the cycle the counter holds 0; the output register shows
    // that count one cycle later, so the pulse is delayed to line up with it.
    ps_d  = wrap_q;
  end

  // State registers with synchronous reset; a reset abandons any period in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      cnt_q  <= 8'h00;
      duty_q <= 8'h00;
      out_q  <= 16'h0000;
      wrap_q <= 1'b0;
      ps_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
      ps_q   <= ps_d;
    end
  end

  assign out          = out_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (prescale 1 and 13) share stimulus.
// A time-based reference predicts every output cycle through a queue, and
// table rows plus measured periods cover the static and waveform behaviour.
`timescale 1ns/1ps
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] eo, ep;
  logic [7:0]  duty;
  logic [15:0] out1, out13;
  logic        ps1, ps13;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(eo[7:0]), .en_reg_out_15_8(eo[15:8]),
    .en_reg_pwm_7_0(ep[7:0]), .en_reg_pwm_15_8(ep[15:8]),
    .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
  );

  pwm_peripheral #(.PRESCALE(13), .CNT_W(16)) dut13 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(eo[7:0]), .en_reg_out_15_8(eo[15:8]),
    .en_reg_pwm_7_0(ep[7:0]), .en_reg_pwm_15_8(ep[15:8]),
    .pwm_duty_cycle(duty), .out(out13), .period_start(ps13)
  );

  typedef struct {
    logic [15:0] o1;
    logic        p1;
    logic [15:0] o13;
    logic        p13;
  } exp_t;

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  duty;
    logic [15:0] exp_static;
  } vec_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state: clock edges since reset and the duty in force.
  int          n1, n13;
  logic [7:0]  sh1, sh13;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts one instance's outputs after the coming edge from elapsed steps.
  task automatic model_one(input int p, inout int n, inout logic [7:0] sh,
                           output logic [15:0] o, output logic ps);
    int   per;
    int   cnt;
    logic raw;
    per = 256 * p;
    if (rst) begin
      o = 16'h0000; ps = 1'b0; n = 0; sh = 8'h00;
    end else begin
      cnt = (n / p) % 256;
      raw = (sh == 8'hFF) ? 1'b1 : (cnt < int'(sh));
      o   = eo & ~(ep & ~{16{raw}});
      ps  = (n > 0) && ((n % per) == 0);
      if ((n % per) == per - 1) sh = duty;
      n++;
    end
  endtask

  task automatic step();
    exp_t e;
    model_one(1,  n1,  sh1,  e.o1,  e.p1);
    model_one(13, n13, sh13, e.o13, e.p13);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("out_p1",  {16'h0, out1},  {16'h0, e.o1});
    chk("ps_p1",   {31'h0, ps1},   {31'h0, e.p1});
    chk("out_p13", {16'h0, out13}, {16'h0, e.o13});
    chk("ps_p13",  {31'h0, ps13},  {31'h0, e.p13});
  endtask

  function automatic logic cur_ps(input int p);
    return (p == 1) ? ps1 : ps13;
  endfunction

  function automatic logic cur_o0(input int p);
    return (p == 1) ? out1[0] : out13[0];
  endfunction

  // Finds the next period_start, then measures high time and length of two periods.
  task automatic measure(input int p, input int chg_at, input logic [7:0] chg_duty,
                         output int hi0, output int len0, output int hi1, output int len1);
    int guard;
    int hi, len;
    hi0 = 0; len0 = 0; hi1 = 0; len1 = 0;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!cur_ps(p) && guard < 2 * 256 * p + 16);
    if (!cur_ps(p)) begin
      chk("ps_timeout", 32'd0, 32'd1);
    end else begin
      for (int k = 0; k < 2; k++) begin
        hi  = cur_o0(p) ? 1 : 0;
        len = 1;
        while (len < 70000) begin
          if (k == 0 && len == chg_at) duty = chg_duty;
          step();
          if (cur_ps(p)) break;
          hi += cur_o0(p) ? 1 : 0;
          len++;
        end
        if (k == 0) begin hi0 = hi; len0 = len; end
        else        begin hi1 = hi; len1 = len; end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    int          h0, l0, h1, l1;
    int          cyc;
    logic [15:0] and_acc, or_acc;

    vecs[0] = '{eo: 16'hFFFF, ep: 16'h0000, duty: 8'h00, exp_static: 16'hFFFF};
    vecs[1] = '{eo: 16'hA5A5, ep: 16'hFF00, duty: 8'h80, exp_static: 16'h00A5};
    vecs[2] = '{eo: 16'h0001, ep: 16'h0001, duty: 8'h80, exp_static: 16'h0000};
    vecs[3] = '{eo: 16'hFF00, ep: 16'h00FF, duty: 8'hFF, exp_static: 16'hFF00};
    vecs[4] = '{eo: 16'h0F0F, ep: 16'hFFFF, duty: 8'h40, exp_static: 16'h0000};

    // Reset with everything enabled: outputs must stay low.
    rst = 1'b1; eo = 16'hFFFF; ep = 16'h0000; duty = 8'h00;
    n1 = 0; n13 = 0; sh1 = 8'h00; sh13 = 8'h00;
    repeat (3) step();
    chk("rst_out1",  {16'h0, out1},  32'h0);
    chk("rst_out13", {16'h0, out13}, 32'h0);
    chk("rst_ps1",   {31'h0, ps1},   32'h0);
    rst = 1'b0;
    step();
    chk("static_hi_out1",  {16'h0, out1},  32'h0000FFFF);
    chk("static_hi_out13", {16'h0, out13}, 32'h0000FFFF);

    // Table rows: static bits and disabled bits checked against constants.
    for (int i = 0; i < 5; i++) begin
      eo = vecs[i].eo; ep = vecs[i].ep; duty = vecs[i].duty;
      repeat (20) step();
      chk("vec_static1",  {16'h0, out1 & ~vecs[i].ep},  {16'h0, vecs[i].exp_static});
      chk("vec_static13", {16'h0, out13 & ~vecs[i].ep}, {16'h0, vecs[i].exp_static});
      chk("vec_off1",     {16'h0, out1 & ~vecs[i].eo},  32'h0);
    end

    // Prescale 1, half duty on pin 0.
    eo = 16'h0001; ep = 16'h0001; duty = 8'h80;
    measure(1, -1, 8'h00, h0, l0, h1, l1);
    chk("p1_d80_hi", h0, 128); chk("p1_d80_len", l0, 256);
    chk("p1_d80_hi2", h1, 128); chk("p1_d80_len2", l1, 256);

    // Zero duty then full duty.
    duty = 8'h00;
    measure(1, -1, 8'h00, h0, l0, h1, l1);
    chk("p1_d00_hi", h0, 0); chk("p1_d00_hi2", h1, 0);
    duty = 8'hFF;
    measure(1, -1, 8'h00, h0, l0, h1, l1);
    chk("p1_dff_hi", h0, 256); chk("p1_dff_hi2", h1, 256);
    chk("p1_dff_len", l0, 256);

    // Prescale 13, quarter duty.
    duty = 8'h40;
    measure(13, -1, 8'h00, h0, l0, h1, l1);
    chk("p13_d40_hi", h0, 832); chk("p13_d40_len", l0, 3328);

    // Duty raised at count 100: current period unchanged, next one uses it.
    measure(13, 100 * 13, 8'hC0, h0, l0, h1, l1);
    chk("p13_chg_hi0", h0, 832);  chk("p13_chg_len0", l0, 3328);
    chk("p13_chg_hi1", h1, 2496); chk("p13_chg_len1", l1, 3328);

    // Mixed enables, reset mid-period, counters restart from zero.
    eo = 16'hA5A5; ep = 16'hFF00; duty = 8'h80;
    repeat (300) step();
    rst = 1'b1;
    step();
    chk("midrst_out1",  {16'h0, out1},  32'h0);
    chk("midrst_out13", {16'h0, out13}, 32'h0);
    rst = 1'b0;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!ps1 && cyc < 1000);
    chk("restart_ps_delay", cyc, 257);
    and_acc = out1; or_acc = out1;
    repeat (255) begin
      step();
      and_acc &= out1;
      or_acc  |= out1;
    end
    chk("mixed_and", {16'h0, and_acc}, 32'h000000A5);
    chk("mixed_or",  {16'h0, or_acc},  32'h0000A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
